// File: rtl/juego_pkg.sv
// juego_pkg: shared types and constants for the tic-tac-toe controller
//   estado_t    controller FSM states
//   JUGADOR_*   player codes (also the value of turno)
//   GANADOR_*   result codes driven on ganador
//   LINEAS      the eight winning-line masks, bit i = cell i
package juego_pkg;
    typedef enum logic [1:0] {ESPERA, VALIDA, EVALUA, FIN} estado_t;
    localparam logic JUGADOR_X = 1'b0;
    localparam logic JUGADOR_O = 1'b1;
    localparam logic [1:0] GANADOR_NINGUNO = 2'b00;
    localparam logic [1:0] GANADOR_X       = 2'b01;
    localparam logic [1:0] GANADOR_O       = 2'b10;
    localparam logic [1:0] GANADOR_EMPATE  = 2'b11;
    localparam int NUM_CELDAS = 9;
    localparam logic [NUM_CELDAS-1:0] LINEAS [8] = '{
        9'h007, 9'h038, 9'h1c0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };
endpackage

// File: rtl/decodificador_posicion.sv
// decodificador_posicion: 4-to-16 one-hot decoder with enable
//   en_i     enable; output is all zero when low
//   pos_i    position to decode
//   onehot_o one-hot select, bit pos_i set when enabled
module decodificador_posicion (
    input  logic        en_i,
    input  logic [3:0]  pos_i,
    output logic [15:0] onehot_o
);
    assign onehot_o = en_i ? (16'h0001 << pos_i) : 16'h0000;
endmodule

// File: rtl/control_juego.sv
// control_juego: turn and game-state controller for the 3x3 board
//   clk, rst_n          clock, async active-low reset
//   reiniciar           sync new-game request, overrides everything
//   mov_valido,posicion move request strobe and requested cell 0-8
//   listo, fin          ready for a move / game over
//   turno               player to move (0 = X, 1 = O)
//   tablero_x/o         cells held by each player
//   ilegal              one-cycle pulse on a rejected move
//   ganador             00 none, 01 X, 10 O, 11 draw
module control_juego
    import juego_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reiniciar,
    input  logic       mov_valido,
    input  logic [3:0] posicion,
    output logic       listo,
    output logic       turno,
    output logic [8:0] tablero_x,
    output logic [8:0] tablero_o,
    output logic       ilegal,
    output logic [1:0] ganador,
    output logic       fin
);
    estado_t               estado_q, estado_d;
    logic [3:0]            pos_q, pos_d;
    logic                  jug_q, jug_d;
    logic                  turno_q, turno_d;
    logic [NUM_CELDAS-1:0] tx_q, tx_d, to_q, to_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            ganador_q, ganador_d;
    logic                  ilegal_q, ilegal_d;
    logic [15:0]           sel;
    logic [NUM_CELDAS-1:0] celda, tablero_mov;
    logic [7:0]            linea_llena;
    logic                  fuera, gana;

    decodificador_posicion u_dec (
        .en_i    (estado_q == VALIDA),
        .pos_i   (pos_q),
        .onehot_o(sel)
    );

    // Positions 9-15 land above the board bits, so they flag the move illegal
    // instead of selecting a cell.
    assign celda = sel[NUM_CELDAS-1:0];
    assign fuera = |sel[15:NUM_CELDAS];
    assign tablero_mov = (jug_q == JUGADOR_O) ? to_q : tx_q;

    always_comb begin
        linea_llena = '0;
        for (int i = 0; i < 8; i++)
            linea_llena[i] = (tablero_mov & LINEAS[i]) == LINEAS[i];
    end
    assign gana = |linea_llena;

    always_comb begin
        estado_d  = estado_q;
        pos_d     = pos_q;
        jug_d     = jug_q;
        turno_d   = turno_q;
        tx_d      = tx_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        ganador_d = ganador_q;
        ilegal_d  = 1'b0;
        case (estado_q)
            ESPERA: if (mov_valido) begin
                pos_d    = posicion;
                jug_d    = turno_q;
                estado_d = VALIDA;
            end
            VALIDA: if (fuera || |(celda & (tx_q | to_q))) begin
                ilegal_d = 1'b1;
                estado_d = ESPERA;
            end else begin
                tx_d     = (jug_q == JUGADOR_X) ? (tx_q | celda) : tx_q;
                to_d     = (jug_q == JUGADOR_O) ? (to_q | celda) : to_q;
                cnt_d    = cnt_q + 4'd1;
                estado_d = EVALUA;
            end
            // A line is tested before the draw count so a 9th-move line wins.
            EVALUA: if (gana) begin
                ganador_d = (jug_q == JUGADOR_O) ? GANADOR_O : GANADOR_X;
                estado_d  = FIN;
            end else if (cnt_q == 4'(NUM_CELDAS)) begin
                ganador_d = GANADOR_EMPATE;
                estado_d  = FIN;
            end else begin
                turno_d  = ~turno_q;
                estado_d = ESPERA;
            end
            FIN:     estado_d = FIN;
            default: estado_d = ESPERA;
        endcase
        if (reiniciar) begin
            estado_d  = ESPERA;
            turno_d   = JUGADOR_X;
            tx_d      = '0;
            to_d      = '0;
            cnt_d     = '0;
            ganador_d = GANADOR_NINGUNO;
            ilegal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= ESPERA;
            pos_q     <= '0;
            jug_q     <= JUGADOR_X;
            turno_q   <= JUGADOR_X;
            tx_q      <= '0;
            to_q      <= '0;
            cnt_q     <= '0;
            ganador_q <= GANADOR_NINGUNO;
            ilegal_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pos_q     <= pos_d;
            jug_q     <= jug_d;
            turno_q   <= turno_d;
            tx_q      <= tx_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
            ganador_q <= ganador_d;
            ilegal_q  <= ilegal_d;
        end
    end

    assign listo     = estado_q == ESPERA;
    assign fin       = estado_q == FIN;
    assign turno     = turno_q;
    assign tablero_x = tx_q;
    assign tablero_o = to_q;
    assign ilegal    = ilegal_q;
    assign ganador   = ganador_q;
endmodule

// File: tb/tb_control_juego.sv
// tb_control_juego: self-checking bench for control_juego
module tb_control_juego;
    logic       clk = 1'b0;
    logic       rst_n, reiniciar, mov_valido;
    logic [3:0] posicion;
    logic       listo, turno, ilegal, fin;
    logic [8:0] tablero_x, tablero_o;
    logic [1:0] ganador;

    control_juego dut (
        .clk(clk), .rst_n(rst_n), .reiniciar(reiniciar), .mov_valido(mov_valido),
        .posicion(posicion), .listo(listo), .turno(turno), .tablero_x(tablero_x),
        .tablero_o(tablero_o), .ilegal(ilegal), .ganador(ganador), .fin(fin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x, o;
        logic       t, f, il;
        logic [1:0] g;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    // reference model of the game
    logic [8:0] mx, mo;
    logic       mt, mf;
    logic [1:0] mg;
    int         mc;
    int trios[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic linea(input logic [8:0] b);
        for (int i = 0; i < 8; i++)
            if (b[trios[i][0]] && b[trios[i][1]] && b[trios[i][2]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mx = '0; mo = '0; mt = 1'b0; mf = 1'b0; mg = 2'b00; mc = 0;
    endtask

    task automatic reinicia();
        @(negedge clk);
        reiniciar = 1'b1;
        @(posedge clk);
        #1 reiniciar = 1'b0;
        model_clear();
    endtask

    // One full move: expectation pushed at drive time, popped when the DUT is ready again.
    task automatic mover(input int p, input string tag);
        exp_t e;
        logic seen;
        int   lat;
        e.il = (p > 8) ? 1'b1 : (mx[p] | mo[p]);
        if (!e.il) begin
            if (mt) mo[p] = 1'b1; else mx[p] = 1'b1;
            mc++;
            if (linea(mt ? mo : mx)) begin mg = mt ? 2'b10 : 2'b01; mf = 1'b1; end
            else if (mc == 9) begin mg = 2'b11; mf = 1'b1; end
            else mt = ~mt;
        end
        e.x = mx; e.o = mo; e.t = mt; e.g = mg; e.f = mf;
        e.lat = e.il ? 2 : 3;
        sb.push_back(e);
        @(negedge clk);
        mov_valido = 1'b1;
        posicion   = 4'(p);
        @(posedge clk);
        #1 mov_valido = 1'b0;
        lat = 0; seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lat++;
            seen = seen | ilegal;
            if (listo || fin) break;
        end
        e = sb.pop_front();
        n_chk++; if (lat != e.lat) begin n_fail++; $display("FAIL %s latency got %0d exp %0d", tag, lat, e.lat); end
        n_chk++; if (seen !== e.il) begin n_fail++; $display("FAIL %s ilegal got %b exp %b", tag, seen, e.il); end
        n_chk++; if (tablero_x !== e.x) begin n_fail++; $display("FAIL %s tablero_x got %h exp %h", tag, tablero_x, e.x); end
        n_chk++; if (tablero_o !== e.o) begin n_fail++; $display("FAIL %s tablero_o got %h exp %h", tag, tablero_o, e.o); end
        n_chk++; if (turno !== e.t) begin n_fail++; $display("FAIL %s turno got %b exp %b", tag, turno, e.t); end
        n_chk++; if (ganador !== e.g) begin n_fail++; $display("FAIL %s ganador got %b exp %b", tag, ganador, e.g); end
        n_chk++; if (fin !== e.f || listo !== !e.f) begin n_fail++; $display("FAIL %s fin/listo got %b/%b exp %b/%b", tag, fin, listo, e.f, !e.f); end
        n_chk++; if ((tablero_x & tablero_o) !== 9'h000) begin n_fail++; $display("FAIL %s overlap got %h exp 000", tag, tablero_x & tablero_o); end
        @(negedge clk);
        n_chk++; if (ilegal !== 1'b0) begin n_fail++; $display("FAIL %s ilegal_width got %b exp 0", tag, ilegal); end
    endtask

    task automatic chk_limpio(input string tag);
        n_chk++;
        if (tablero_x !== 9'h0 || tablero_o !== 9'h0 || turno !== 1'b0 || ganador !== 2'b00 ||
            listo !== 1'b1 || fin !== 1'b0 || ilegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got x=%h o=%h t=%b g=%b listo=%b fin=%b il=%b exp x=000 o=000 t=0 g=00 listo=1 fin=0 il=0",
                     tag, tablero_x, tablero_o, turno, ganador, listo, fin, ilegal);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reiniciar = 1'b0; mov_valido = 1'b0; posicion = '0;
        model_clear();
        #12;
        chk_limpio("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_legal();
        reinicia();
        mover(4, "x4");
        n_chk++; if (tablero_x !== 9'h010 || turno !== 1'b1) begin n_fail++; $display("FAIL legal_x got x=%h t=%b exp x=010 t=1", tablero_x, turno); end
        mover(0, "o0");
        n_chk++; if (tablero_o !== 9'h001 || turno !== 1'b0) begin n_fail++; $display("FAIL legal_o got o=%h t=%b exp o=001 t=0", tablero_o, turno); end
    endtask

    task automatic test_ilegal();
        reinicia();
        mover(4, "x4b");
        mover(4, "o4_ocupada");
        n_chk++; if (turno !== 1'b1) begin n_fail++; $display("FAIL ilegal_turno got %b exp 1", turno); end
        mover(12, "pos12");
    endtask

    task automatic test_win();
        reinicia();
        mover(0, "w_x0"); mover(3, "w_o3"); mover(1, "w_x1"); mover(4, "w_o4"); mover(2, "w_x2");
        n_chk++; if (ganador !== 2'b01 || fin !== 1'b1 || listo !== 1'b0) begin n_fail++; $display("FAIL win got g=%b fin=%b listo=%b exp 01 1 0", ganador, fin, listo); end
        @(negedge clk);
        mov_valido = 1'b1; posicion = 4'd8;
        repeat (4) @(negedge clk);
        mov_valido = 1'b0;
        n_chk++; if (tablero_x !== 9'h007 || tablero_o !== 9'h018 || fin !== 1'b1 || ganador !== 2'b01) begin
            n_fail++; $display("FAIL fin_hold got x=%h o=%h fin=%b g=%b exp 007 018 1 01", tablero_x, tablero_o, fin, ganador);
        end
        reinicia();
        @(negedge clk);
        chk_limpio("reiniciar_fin");
    endtask

    task automatic test_draw();
        int seq[9] = '{4, 0, 2, 6, 3, 5, 1, 7, 8};
        reinicia();
        foreach (seq[i]) mover(seq[i], "draw");
        n_chk++; if (ganador !== 2'b11 || fin !== 1'b1) begin n_fail++; $display("FAIL draw got g=%b fin=%b exp 11 1", ganador, fin); end
    endtask

    task automatic test_win9();
        int seq[9] = '{0, 1, 2, 3, 6, 5, 8, 7, 4};
        reinicia();
        foreach (seq[i]) mover(seq[i], "win9");
        n_chk++; if (ganador !== 2'b01) begin n_fail++; $display("FAIL win9 got g=%b exp 01", ganador); end
    endtask

    task automatic test_reiniciar();
        reinicia();
        mover(4, "r_x4");
        @(negedge clk);
        mov_valido = 1'b1; posicion = 4'd0;
        @(posedge clk);
        #1 mov_valido = 1'b0;
        @(posedge clk);
        #1 reiniciar = 1'b1;
        @(posedge clk);
        #1 reiniciar = 1'b0;
        model_clear();
        @(negedge clk);
        chk_limpio("reiniciar_evalua");
        mov_valido = 1'b1; posicion = 4'd3;
        @(posedge clk);
        #1 mov_valido = 1'b0; reiniciar = 1'b1;
        @(posedge clk);
        #1 reiniciar = 1'b0;
        @(negedge clk);
        chk_limpio("reiniciar_valida");
    endtask

    task automatic test_async();
        reinicia();
        mover(4, "a_x4");
        mover(0, "a_o0");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_limpio("async_reset");
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_ignore();
        reinicia();
        @(negedge clk);
        mov_valido = 1'b1; posicion = 4'd2;
        @(posedge clk);
        #1 posicion = 4'd5;
        @(posedge clk);
        @(posedge clk);
        #1 mov_valido = 1'b0;
        @(negedge clk);
        n_chk++; if (tablero_x !== 9'h004 || tablero_o !== 9'h000 || turno !== 1'b1 || listo !== 1'b1) begin
            n_fail++; $display("FAIL ignore got x=%h o=%h t=%b listo=%b exp 004 000 1 1", tablero_x, tablero_o, turno, listo);
        end
    endtask

    task automatic test_back_to_back();
        reinicia();
        @(negedge clk);
        mov_valido = 1'b1; posicion = 4'd6;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 mov_valido = 1'b0;
        @(negedge clk);
        n_chk++; if (ilegal !== 1'b1 || tablero_x !== 9'h040 || tablero_o !== 9'h000 || turno !== 1'b1) begin
            n_fail++; $display("FAIL held_repeat got il=%b x=%h o=%h t=%b exp 1 040 000 1", ilegal, tablero_x, tablero_o, turno);
        end
        @(negedge clk);
        n_chk++; if (ilegal !== 1'b0) begin n_fail++; $display("FAIL held_pulse got %b exp 0", ilegal); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_legal();
        test_ilegal();
        test_win();
        test_draw();
        test_win9();
        test_reiniciar();
        test_async();
        test_ignore();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/control_juego.md
# control_juego

Turn and game-state controller for the 3x3 tic-tac-toe datapath. Accepts one move request at a time, decodes the 4-bit board position to a one-hot cell select, rejects illegal moves, commits legal ones to the X/O board registers, alternates turns, and detects win or draw. Sits between the player-input logic and the display/winner logic; it is the sole writer of the board state.

## Interface
- Parameters: none (3x3 board fixed; positions 0-8 valid, 9-15 illegal).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reiniciar` in 1: synchronous new-game request; highest priority.
- `mov_valido` in 1: move request strobe.
- `posicion` in 4: requested cell, row-major, 0 = top-left, 8 = bottom-right.
- `listo` out 1: ready to accept a move; high only in ESPERA.
- `turno` out 1: player to move; 0 = X, 1 = O.
- `tablero_x` out 9: cells held by X, bit i = cell i.
- `tablero_o` out 9: cells held by O.
- `ilegal` out 1: one-cycle pulse when a move is rejected.
- `ganador` out 2: 00 none, 01 X wins, 10 O wins, 11 draw.
- `fin` out 1: game over; high in FIN.

## Operation
- States: ESPERA, VALIDA, EVALUA, FIN.
- ESPERA: `listo`=1. On `mov_valido`=1, latch `posicion`, latch the current player, and go to VALIDA. `mov_valido` in any other state is ignored, with no queuing.
- VALIDA: decode the latched position to one-hot. The move is illegal if `posicion` > 8 or the cell is set in `tablero_x | tablero_o`.
  - Illegal: pulse `ilegal`, leave board and `turno` unchanged, return to ESPERA.
  - Legal: set the cell bit in the mover's board, increment move counter (4-bit, 0-9), go to EVALUA.
- EVALUA: test the mover's board against 8 line masks: rows {0,1,2} {3,4,5} {6,7,8}; columns {0,3,6} {1,4,7} {2,5,8}; diagonals {0,4,8} {2,4,6}.
  - Any full line: `ganador` = mover code, go to FIN.
  - Otherwise, if the counter = 9: `ganador`=11, go to FIN.
  - Otherwise: toggle `turno`, go to ESPERA.
- A completed line on the 9th move is a win, not a draw.
- FIN: hold board, `ganador`, `turno`. `fin`=1, `listo`=0. Leave only via `reiniciar` or reset.
- `reiniciar`=1 at any clock edge, in any state, takes precedence over `mov_valido` and FSM progress. It does the following:
  - clear both boards and the counter;
  - `turno`=0, `ganador`=00, `ilegal`=0;
  - state = ESPERA.
- `rst_n` low: same values as `reiniciar`, applied asynchronously. All outputs are registered or decoded from registered state. Reset values: `listo`=1, `turno`=0, `tablero_x`=`tablero_o`=0, `ilegal`=0, `ganador`=00, `fin`=0.
- Invariant: `tablero_x & tablero_o` = 0 always.

## Timing
- Accept at edge E0 (ESPERA, `mov_valido`=1). VALIDA occupies the cycle after E0.
- Illegal move: `ilegal`=1 for exactly the one cycle after edge E1, coincident with `listo`=1. Accept-to-ready is 2 cycles.
- Legal move: board bit is visible after E1. `turno` toggle or `ganador`/`fin` update is visible after E2. `listo` returns after E2, so accept-to-ready is 3 cycles.
- Minimum spacing between accepted moves is 3 cycles. A `mov_valido` held high re-issues the same move on the next ESPERA; that repeat is rejected as occupied.
- `reiniciar` asserted in VALIDA or EVALUA aborts the pending move; no board bit is written.

## Structure
- Shared package `juego_pkg` holds:
  - the state enum;
  - JUGADOR_X=0, JUGADOR_O=1;
  - GANADOR_NINGUNO/X/O/EMPATE codes;
  - the 8 nine-bit line masks;
  - NUM_CELDAS=9.
- Sub-module `decodificador_posicion`: combinational 4-to-16 one-hot decoder with enable, output 0 when disabled. The controller uses bits [8:0] and treats positions 9-15 as illegal before indexing.
- Win check stays inline in the controller as an OR-reduction over the masked compares.

## Test plan
- Reset, then X plays 4 and O plays 0: after the X move, `tablero_x`=9'h010 and `turno`=1. After the O move, `tablero_o`=9'h001 and `turno`=0. `ilegal` never pulses.
- X plays 4, then O plays 4: one `ilegal` pulse, boards unchanged, `turno` stays 1. Also `posicion`=12 from ESPERA: `ilegal` pulses, state returns to ESPERA.
- X plays 0, O plays 3, X plays 1, O plays 4, X plays 2: `ganador`=01, `fin`=1, `listo`=0. A subsequent `mov_valido` with `posicion`=8 is ignored and the boards are unchanged.
- Full draw sequence X4 O0 X2 O6 X3 O5 X1 O7 X8: `ganador`=11 after the 9th move. Separately, a 9th move that completes a line must report a win, not a draw.
- `reiniciar` pulsed in EVALUA mid-move and again in FIN: both boards 0, `turno`=0, `ganador`=00, `listo`=1 on the next cycle. `rst_n` pulled low asynchronously mid-game gives the same values immediately, without waiting for a clock edge.
- `mov_valido` asserted during VALIDA and EVALUA with a different `posicion`: ignored. Only the originally latched cell is written.
